// File: rtl/bcp_clause_scanner.sv
// Clause-table scanner for hardware BCP: walks every clause entry against a
// captured assignment and streams matching clause indices over valid/ready.
module bcp_clause_scanner #(
  parameter int VAR_NUM    = 8,
  parameter int CLAUSE_NUM = 16,
  parameter int IDX_W      = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [VAR_NUM-1:0] cfg_type,
  input  logic [VAR_NUM-1:0] cfg_mask,
  input  logic               cfg_valid,
  input  logic               start,
  input  logic               abort,
  input  logic [VAR_NUM-1:0] assignment,
  output logic               busy,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               done,
  output logic [IDX_W:0]     hit_count
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t state_reg, state_next;

  logic [VAR_NUM-1:0]    type_reg [CLAUSE_NUM];
  logic [VAR_NUM-1:0]    mask_reg [CLAUSE_NUM];
  logic [CLAUSE_NUM-1:0] valid_reg;

  logic [VAR_NUM-1:0] assign_reg, assign_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   hit_idx_reg, hit_idx_next;
  logic [IDX_W:0]     hit_count_reg, hit_count_next;

  logic cfg_open;
  logic entry_match;
  logic last_idx;

  // Writes only land while idle, so a running scan always sees a frozen table.
  assign cfg_open = cfg_we && (state_reg == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < CLAUSE_NUM; gi++) begin : g_entry
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg[gi] <= 1'b0;
          type_reg[gi]  <= '0;
          mask_reg[gi]  <= '0;
        end else if (cfg_open && (cfg_addr == IDX_W'(gi))) begin
          valid_reg[gi] <= cfg_valid;
          type_reg[gi]  <= cfg_type;
          mask_reg[gi]  <= cfg_mask;
        end
      end
    end
  endgenerate

  // A present literal fails when the variable value disagrees with its polarity.
  assign entry_match = valid_reg[idx_reg] &
                       ~|(mask_reg[idx_reg] & (assign_reg ^ type_reg[idx_reg]));
  assign last_idx    = (idx_reg == IDX_W'(CLAUSE_NUM - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      assign_reg    <= '0;
      idx_reg       <= '0;
      hit_idx_reg   <= '0;
      hit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      assign_reg    <= assign_next;
      idx_reg       <= idx_next;
      hit_idx_reg   <= hit_idx_next;
      hit_count_reg <= hit_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    assign_next    = assign_reg;
    idx_next       = idx_reg;
    hit_idx_next   = hit_idx_reg;
    hit_count_next = hit_count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          assign_next    = assignment;
          idx_next       = '0;
          hit_count_next = '0;
          state_next     = SCAN;
        end
      end
      SCAN: begin
        if (entry_match) begin
          hit_idx_next = idx_reg;
          state_next   = EMIT;
        end else if (last_idx) begin
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      EMIT: begin
        if (hit_ready) begin
          hit_count_next = hit_count_reg + 1'b1;
          if (last_idx) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = SCAN;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a handshake in the same cycle.
    if (abort && (state_reg != IDLE)) begin
      state_next     = IDLE;
      hit_count_next = hit_count_reg;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign hit_valid = (state_reg == EMIT);
  assign done      = (state_reg == DONE);
  assign hit_idx   = hit_idx_reg;
  assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Directed bench for bcp_clause_scanner: a clause-table model predicts the hit
// list of each scan and a negedge monitor checks the hit stream against it.
module tb_bcp_clause_scanner;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_type = '0;
  logic [7:0] cfg_mask = '0;
  logic       cfg_valid = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] assignment = '0;
  logic       busy;
  logic       hit_valid;
  logic       hit_ready = 1'b1;
  logic [3:0] hit_idx;
  logic       done;
  logic [4:0] hit_count;

  bcp_clause_scanner #(.VAR_NUM(8), .CLAUSE_NUM(16), .IDX_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_type(cfg_type),
    .cfg_mask(cfg_mask), .cfg_valid(cfg_valid),
    .start(start), .abort(abort), .assignment(assignment),
    .busy(busy), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_idx(hit_idx), .done(done), .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the clause table and of the expected hit stream.
  logic [7:0] m_type [16];
  logic [7:0] m_mask [16];
  bit         m_valid [16];
  int         exp_q[$];
  int         model_cnt = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("mon_busy", int'(busy), 1);
      if (hit_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_hit_unexpected", int'(hit_idx), -1);
        end else begin
          chk("mon_hit_idx", int'(hit_idx), exp_q[0]);
          if (hit_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        chk("mon_done_pending", exp_q.size(), 0);
        chk("mon_done_count", int'(hit_count), model_cnt);
      end
    end
  end

  task automatic clear_model();
    for (int e = 0; e < 16; e++) begin
      m_valid[e] = 1'b0;
      m_type[e]  = 8'h00;
      m_mask[e]  = 8'h00;
    end
  endtask

  task automatic write_entry(input int addr, input logic [7:0] t, input logic [7:0] m,
                             input bit v);
    @(posedge clock); #1;
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_type = t; cfg_mask = m; cfg_valid = v;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    m_valid[addr] = v; m_type[addr] = t; m_mask[addr] = m;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_hit_valid"}, int'(hit_valid), 0);
    chk({tag, "_hit_idx"}, int'(hit_idx), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_hit_count"}, int'(hit_count), 0);
  endtask

  // exp_cnt is the hand-computed number of matching clauses for this scan.
  task automatic run_scan(input string tag, input logic [7:0] a, input int stall_first,
                          input int inject_at, input int abort_idx,
                          input int exp_lat, input int exp_cnt);
    int  n;
    int  stall;
    int  partial;
    bit  got_done;
    bit  aborted;
    bit  seen;
    exp_q.delete();
    partial = 0;
    for (int e = 0; e < 16; e++) begin
      if (m_valid[e] && (((a ^ m_type[e]) & m_mask[e]) == 8'h00)) begin
        exp_q.push_back(e);
        if (abort_idx >= 0 && e < abort_idx) partial++;
      end
    end
    model_cnt = exp_q.size();
    chk({tag, "_model_cnt"}, model_cnt, exp_cnt);

    @(posedge clock); #1;
    start = 1'b1; assignment = a; hit_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; assignment = ~a; mon_en = 1'b1;
    n = 0; stall = stall_first; got_done = 1'b0; aborted = 1'b0;
    while (!got_done && !aborted && n < 200) begin
      start     = (n == inject_at);
      cfg_we    = (n == inject_at);
      cfg_addr  = 4'd5; cfg_type = 8'h00; cfg_mask = 8'h00; cfg_valid = 1'b1;
      if (abort_idx >= 0 && hit_valid && int'(hit_idx) == abort_idx) begin
        abort = 1'b1; mon_en = 1'b0; hit_ready = 1'b0; aborted = 1'b1;
      end else if (hit_valid && stall > 0) begin
        hit_ready = 1'b0; stall--;
      end else begin
        hit_ready = 1'b1;
      end
      @(negedge clock);
      n++;
      if (!aborted) begin
        if (done) got_done = 1'b1;
        else begin @(posedge clock); #1; end
      end
    end
    #1;
    mon_en = 1'b0; start = 1'b0; cfg_we = 1'b0; hit_ready = 1'b1;

    if (aborted) begin
      @(posedge clock); #1;
      abort = 1'b0;
      @(negedge clock);
      chk({tag, "_abort_busy"}, int'(busy), 0);
      chk({tag, "_abort_hit_valid"}, int'(hit_valid), 0);
      chk({tag, "_abort_done"}, int'(done), 0);
      chk({tag, "_abort_partial"}, int'(hit_count), partial);
      seen = 1'b0;
      repeat (20) begin
        @(negedge clock);
        if (done) seen = 1'b1;
      end
      chk({tag, "_abort_no_done"}, int'(seen), 0);
    end else begin
      chk({tag, "_done_seen"}, int'(got_done), 1);
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_hit_count"}, int'(hit_count), exp_cnt);
      @(negedge clock);
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_idle_busy"}, int'(busy), 0);
    end
    $display("scan %s: assignment=%02h hits=%0d cycles=%0d aborted=%0d", tag, a,
             int'(hit_count), n, int'(aborted));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  found;
    clear_model();
    #2;
    check_reset("por");
    #10 reset_n = 1'b1;

    run_scan("empty", 8'h00, 0, -1, -1, 17, 0);

    write_entry(3, 8'hA5, 8'h0F, 1'b1);
    run_scan("e3_match", 8'h35, 0, -1, -1, 18, 1);
    run_scan("e3_miss", 8'h34, 0, -1, -1, 17, 0);

    write_entry(3, 8'h00, 8'h00, 1'b0);
    write_entry(0, 8'h3C, 8'h00, 1'b1);
    write_entry(7, 8'hFF, 8'h00, 1'b1);
    write_entry(15, 8'h81, 8'h00, 1'b1);
    run_scan("vacuous_stall", 8'h5A, 5, -1, -1, 25, 3);

    run_scan("busy_ignore", 8'hC3, 0, 3, -1, 20, 3);
    run_scan("table_kept", 8'hFF, 0, -1, -1, 20, 3);

    run_scan("abort_emit7", 8'h00, 0, -1, 7, 0, 3);

    // Reset asserted between edges while the scanner is presenting hit 7.
    @(posedge clock); #1;
    start = 1'b1; assignment = 8'h11;
    @(posedge clock); #1;
    start = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 60) begin
      if (hit_valid && hit_idx == 4'd7) found = 1'b1;
      else begin @(posedge clock); #1; k++; end
    end
    chk("midreset_reach_hit7", int'(found), 1);
    #2 reset_n = 1'b0;
    #1 check_reset("midreset");
    clear_model();
    #3 reset_n = 1'b1;
    run_scan("after_reset", 8'h11, 0, -1, -1, 17, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcp_clause_scanner.md
Name: bcp_clause_scanner

Overview:
- Sequences a small on-chip clause table through the per-clause literal-match check used by hardware BCP.
- On `start`, captures a variable assignment and scans every valid clause entry in index order, one per cycle.
- Streams the index of each matching clause over a valid/ready handshake, then pulses `done` with the total match count.
- Sits between the BCP control FSM (start, done, hit consumer) and the clause configuration loader (write port).

Parameters:
- VAR_NUM, 8, number of variables / literal bit positions per clause
- CLAUSE_NUM, 16, number of clause table entries
- IDX_W, 4, clause index width; CLAUSE_NUM <= 2**IDX_W

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write clause entry at cfg_addr (ignored while busy)
- cfg_addr  in  IDX_W  entry index; writes with cfg_addr >= CLAUSE_NUM ignored
- cfg_type  in  VAR_NUM  literal polarity per variable
- cfg_mask  in  VAR_NUM  1 = variable present in clause
- cfg_valid  in  1  value written to entry valid bit (0 = delete entry)
- start  in  1  begin scan (accepted only in IDLE)
- abort  in  1  synchronous abort; return to IDLE, no done pulse
- assignment  in  VAR_NUM  variable values, sampled on accepted start
- busy  out  1  state != IDLE
- hit_valid  out  1  hit_idx holds a matching clause index
- hit_ready  in  1  consumer accepts hit
- hit_idx  out  IDX_W  matching clause index
- done  out  1  one-cycle pulse, scan complete
- hit_count  out  IDX_W+1  matches accepted in last scan; held until next start

Behaviour:
- Reset (async, reset_n=0): state IDLE; all entry valid bits 0; busy=0, hit_valid=0, hit_idx=0, done=0, hit_count=0; scan index 0; assignment register 0.
- Match function for entry e with captured assignment A: match = valid[e] & AND over i of (~mask[i] | ~(A[i] ^ type[i])).
- An entry with mask=0 and valid=1 matches vacuously. Invalid entries never match.
- Clause table is a flop array with combinational read.
- cfg writes take effect at the clock edge, only in IDLE. A write in the same cycle as an accepted start is performed, but the scan uses the post-write table.
- FSM:
  - IDLE: start=1 -> capture assignment, idx=0, hit_count=0 -> SCAN.
  - SCAN: evaluate entry idx.
    - match -> hit_idx=idx, hit_valid=1 -> EMIT.
    - no match, idx==CLAUSE_NUM-1 -> DONE.
    - no match, otherwise -> idx+1, stay in SCAN.
  - EMIT: hit_valid held with hit_idx stable until hit_ready=1. On the handshake: hit_valid=0, hit_count+1; then idx==CLAUSE_NUM-1 -> DONE, else idx+1 -> SCAN.
  - DONE: done=1 for exactly this cycle -> IDLE.
- hit_valid is asserted only in EMIT and does not depend on hit_ready. hit_ready=1 held continuously costs one EMIT cycle per hit.
- Latency, start accepted at edge T:
  - Zero hits: SCAN for CLAUSE_NUM cycles, done high in cycle T+CLAUSE_NUM+1.
  - Each hit adds (1 + stall cycles).
- busy is high from the cycle after the accepted start through the DONE cycle inclusive.
- start while busy: ignored. assignment changes during a scan: ignored (captured copy used).
- abort (any non-IDLE state): next state IDLE, hit_valid=0, no done. hit_count keeps the partial count. abort has priority over every other transition. abort in IDLE: no effect.
- reset_n low mid-scan: immediate return to the reset values above, including clearing the table.
- hit_count does not wrap: the maximum is CLAUSE_NUM, which fits in IDX_W+1 bits.

Test Plan:
- Reset, write nothing, start → 16 SCAN cycles, no hit_valid, done at start+17, hit_count=0.
- Entry 3: type=8'hA5, mask=8'h0F, valid=1. Start with assignment=8'h35 (low nibble 5 matches), hit_ready=1 → one hit with hit_idx=3, done at start+18, hit_count=1. Repeat with assignment=8'h34 → no hit, hit_count=0.
- Entries 0, 7, 15 valid with mask=0. hit_ready low for 5 cycles on the first hit → hit_idx sequence 0, 7, 15; hit_idx stable while stalled; hit_count=3; done at start+17+3+5.
- Start during a scan, and cfg_we during a scan to entry 5 → both ignored; table and the in-progress scan unchanged.
- abort asserted while in EMIT for idx 7 → IDLE next cycle, hit_valid=0, no done pulse, busy=0.
- reset_n pulsed low mid-scan (asynchronously, between edges) → outputs go to reset values immediately; a later start with the same assignment yields hit_count=0.
